// File: rtl/mem_stage_hs.sv
// M->W pipeline stage: XLEN-generic load/store unit with a request/ready data-memory
// handshake, byte enables, load extension and misaligned/illegal-size exceptions.
module mem_stage_hs #(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int RSW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [RSW-1:0]    result_src_m,
    input  logic [2:0]        funct3_m,
    input  logic [RAW-1:0]    rd_m,
    input  logic [XLEN-1:0]   pc_plus4_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   write_data_m,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              reg_write_w,
    output logic [RSW-1:0]    result_src_w,
    output logic [RAW-1:0]    rd_w,
    output logic [XLEN-1:0]   pc_plus4_w,
    output logic [XLEN-1:0]   alu_result_w,
    output logic [XLEN-1:0]   read_data_w,
    output logic              exc_w
);
    localparam int BW   = XLEN / 8;
    localparam int OFFW = $clog2(BW);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic              access, size_ok, aligned, legal, req_now, busy;
    logic [OFFW-1:0]   off, align_mask, lat_off, ext_off;
    logic [2:0]        lat_f3, ext_f3;
    logic              lat_we;
    logic [XLEN-1:0]   lat_addr, lat_wdata, addr_now, wdata_now, shifted, ext;
    logic [BW-1:0]     lat_be, be_mask, be_now;

    assign busy    = (state == BUSY);
    assign off     = alu_result_m[OFFW-1:0];
    assign access  = valid_m & (mem_read_m | mem_write_m);
    assign size_ok = (funct3_m != 3'b111) &&
                     !((XLEN == 32) && (funct3_m == 3'b011 || funct3_m == 3'b110));
    assign align_mask = OFFW'((4'd1 << funct3_m[1:0]) - 4'd1);
    assign aligned = ((off & align_mask) == '0);
    assign legal   = size_ok & aligned;
    // rst_n gate keeps the combinational request quiet while reset is held
    assign req_now = rst_n & ~busy & access & legal;

    always_comb begin
        be_mask = '1;
        case (funct3_m[1:0])
            2'b00:   be_mask = BW'(1);
            2'b01:   be_mask = BW'(3);
            2'b10:   be_mask = BW'(15);
            default: be_mask = '1;
        endcase
    end

    assign be_now    = be_mask << off;
    assign addr_now  = {alu_result_m[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign wdata_now = write_data_m << {off, 3'b000};

    assign mem_req   = busy | req_now;
    assign mem_we    = busy ? lat_we    : mem_write_m;
    assign mem_addr  = busy ? lat_addr  : addr_now;
    assign mem_be    = busy ? lat_be    : be_now;
    assign mem_wdata = busy ? lat_wdata : wdata_now;
    assign stall_m   = mem_req & ~mem_ready;

    // Load extraction uses the size/offset captured with the request
    assign ext_off = busy ? lat_off : off;
    assign ext_f3  = busy ? lat_f3  : funct3_m;
    assign shifted = mem_rdata >> {ext_off, 3'b000};

    always_comb begin
        ext = shifted;
        case (ext_f3)
            3'b000:  ext = XLEN'($signed(shifted[7:0]));
            3'b001:  ext = XLEN'($signed(shifted[15:0]));
            3'b010:  ext = XLEN'($signed(shifted[31:0]));
            3'b100:  ext = XLEN'(shifted[7:0]);
            3'b101:  ext = XLEN'(shifted[15:0]);
            3'b110:  ext = XLEN'(shifted[31:0]);
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_be       <= '0;
            lat_wdata    <= '0;
            lat_off      <= '0;
            lat_f3       <= '0;
            reg_write_w  <= 1'b0;
            result_src_w <= '0;
            rd_w         <= '0;
            pc_plus4_w   <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            exc_w        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_now && !mem_ready) begin
                    state     <= BUSY;
                    lat_we    <= mem_write_m;
                    lat_addr  <= addr_now;
                    lat_be    <= be_now;
                    lat_wdata <= wdata_now;
                    lat_off   <= off;
                    lat_f3    <= funct3_m;
                end
                BUSY: if (mem_ready) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!valid_m || stall_m) begin
                reg_write_w  <= 1'b0;
                result_src_w <= '0;
                rd_w         <= '0;
                pc_plus4_w   <= '0;
                alu_result_w <= '0;
                read_data_w  <= '0;
                exc_w        <= 1'b0;
            end else begin
                reg_write_w  <= reg_write_m & ~(access & ~legal);
                result_src_w <= result_src_m;
                rd_w         <= rd_m;
                pc_plus4_w   <= pc_plus4_m;
                alu_result_w <= alu_result_m;
                read_data_w  <= (mem_req & mem_read_m) ? ext : '0;
                exc_w        <= access & ~legal;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench: XLEN=32 and XLEN=64 instances share control inputs, each with its own data buses.
module tb_mem_stage_hs;
    logic clk = 1'b0, rst_n = 1'b0;
    logic valid, rw, mr, mw, ready;
    logic [1:0] rs;
    logic [2:0] f3;
    logic [4:0] rd;

    logic [31:0] pc32, alu32, wd32, rdata32, addr32, wdat32, pc_w32, alu_w32, read_w32;
    logic [3:0]  be32;
    logic [1:0]  rs_w32, rs_w64;
    logic [4:0]  rd_w32, rd_w64;
    logic        stall32, req32, we32, rw_w32, exc32;

    logic [63:0] pc64, alu64, wd64, rdata64, addr64, wdat64, pc_w64, alu_w64, read_w64;
    logic [7:0]  be64;
    logic        stall64, req64, we64, rw_w64, exc64;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mem_stage_hs #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .valid_m(valid), .reg_write_m(rw), .mem_read_m(mr),
        .mem_write_m(mw), .result_src_m(rs), .funct3_m(f3), .rd_m(rd), .pc_plus4_m(pc32),
        .alu_result_m(alu32), .write_data_m(wd32), .stall_m(stall32), .mem_req(req32),
        .mem_we(we32), .mem_addr(addr32), .mem_be(be32), .mem_wdata(wdat32),
        .mem_ready(ready), .mem_rdata(rdata32), .reg_write_w(rw_w32), .result_src_w(rs_w32),
        .rd_w(rd_w32), .pc_plus4_w(pc_w32), .alu_result_w(alu_w32), .read_data_w(read_w32),
        .exc_w(exc32));

    mem_stage_hs #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .valid_m(valid), .reg_write_m(rw), .mem_read_m(mr),
        .mem_write_m(mw), .result_src_m(rs), .funct3_m(f3), .rd_m(rd), .pc_plus4_m(pc64),
        .alu_result_m(alu64), .write_data_m(wd64), .stall_m(stall64), .mem_req(req64),
        .mem_we(we64), .mem_addr(addr64), .mem_be(be64), .mem_wdata(wdat64),
        .mem_ready(ready), .mem_rdata(rdata64), .reg_write_w(rw_w64), .result_src_w(rs_w64),
        .rd_w(rd_w64), .pc_plus4_w(pc_w64), .alu_result_w(alu_w64), .read_data_w(read_w64),
        .exc_w(exc64));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic issue(input logic [2:0] f, input logic ld, input logic st,
                         input logic [63:0] addr, input logic [63:0] wdata);
        valid = 1'b1; f3 = f; mr = ld; mw = st; rw = ld; rs = ld ? 2'b01 : 2'b00; rd = 5'd7;
        alu32 = addr[31:0]; alu64 = addr; wd32 = wdata[31:0]; wd64 = wdata;
    endtask

    initial begin
        valid = 0; rw = 0; mr = 0; mw = 0; ready = 0; rs = 0; f3 = 0; rd = 0;
        pc32 = 0; alu32 = 0; wd32 = 0; rdata32 = 0; pc64 = 0; alu64 = 0; wd64 = 0; rdata64 = 0;
        #2;
        chk("rst_req", 64'(req32), 64'h0);
        chk("rst_stall", 64'(stall32), 64'h0);
        chk("rst_rw", 64'(rw_w32), 64'h0);
        chk("rst_exc", 64'(exc32), 64'h0);
        chk("rst_rdata", 64'(read_w32), 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // LB, zero wait states
        @(negedge clk) issue(3'b000, 1, 0, 64'h103, 64'h0); rdata32 = 32'h80AA_BBCC; ready = 1;
        #1 chk("lb_req", 64'(req32), 64'h1);
        chk("lb_stall", 64'(stall32), 64'h0);
        chk("lb_be", 64'(be32), 64'h8);
        chk("lb_addr", 64'(addr32), 64'h100);
        @(posedge clk); #1 chk("lb_data", 64'(read_w32), 64'hFFFF_FF80);
        chk("lb_rw", 64'(rw_w32), 64'h1);
        chk("lb_rd", 64'(rd_w32), 64'h7);

        // LHU with three wait states
        @(negedge clk) issue(3'b101, 1, 0, 64'h102, 64'h0); ready = 0; rdata32 = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk("lhu_stall", 64'(stall32), 64'h1);
            chk("lhu_addr", 64'(addr32), 64'h100);
            chk("lhu_be", 64'(be32), 64'hC);
            @(posedge clk); #1 chk("lhu_bubble", 64'(rw_w32), 64'h0);
        end
        @(negedge clk) ready = 1; rdata32 = 32'h9234_5678;
        #1 chk("lhu_nostall", 64'(stall32), 64'h0);
        @(posedge clk); #1 chk("lhu_data", 64'(read_w32), 64'h9234);
        chk("lhu_rw", 64'(rw_w32), 64'h1);
        chk("lhu_rs", 64'(rs_w32), 64'h1);

        // SB lane shift
        @(negedge clk) issue(3'b000, 0, 1, 64'h201, 64'hA5); ready = 1;
        #1 chk("sb_we", 64'(we32), 64'h1);
        chk("sb_be", 64'(be32), 64'h2);
        chk("sb_wdata", 64'(wdat32), 64'hA500);
        chk("sb_req", 64'(req32), 64'h1);
        @(posedge clk); #1 chk("sb_rw", 64'(rw_w32), 64'h0);

        // Misaligned LW
        @(negedge clk) issue(3'b010, 1, 0, 64'h102, 64'h0); ready = 0;
        #1 chk("mis_req", 64'(req32), 64'h0);
        chk("mis_stall", 64'(stall32), 64'h0);
        @(posedge clk); #1 chk("mis_exc", 64'(exc32), 64'h1);
        chk("mis_rw", 64'(rw_w32), 64'h0);
        chk("mis_addr", 64'(alu_w32), 64'h102);
        @(negedge clk) valid = 0; ready = 1;
        #1 chk("idle_ready_req", 64'(req32), 64'h0);
        @(posedge clk); #1 chk("exc_1cyc", 64'(exc32), 64'h0);
        chk("bubble_rw", 64'(rw_w32), 64'h0);

        // Non-access pass-through
        @(negedge clk) issue(3'b000, 0, 0, 64'h1234, 64'h0); rw = 1; pc32 = 32'h2004; ready = 0;
        #1 chk("alu_req", 64'(req32), 64'h0);
        @(posedge clk); #1 chk("alu_res", 64'(alu_w32), 64'h1234);
        chk("alu_pc", 64'(pc_w32), 64'h2004);
        chk("alu_rw", 64'(rw_w32), 64'h1);

        // LD: legal on XLEN=64 with one wait, illegal size on XLEN=32
        @(negedge clk) issue(3'b011, 1, 0, 64'h8, 64'h0); ready = 0;
        #1 chk("ld_req64", 64'(req64), 64'h1);
        chk("ld_stall64", 64'(stall64), 64'h1);
        chk("ld_be64", 64'(be64), 64'hFF);
        chk("ld_addr64", addr64, 64'h8);
        chk("ld_req32", 64'(req32), 64'h0);
        @(posedge clk); #1 chk("ld_exc32", 64'(exc32), 64'h1);
        chk("ld_bubble64", 64'(rw_w64), 64'h0);
        @(negedge clk) ready = 1; rdata64 = 64'h1122_3344_5566_7788;
        #1 chk("ld_nostall64", 64'(stall64), 64'h0);
        @(posedge clk); #1 chk("ld_data64", read_w64, 64'h1122_3344_5566_7788);
        chk("ld_rw64", 64'(rw_w64), 64'h1);

        // LW upper lane on XLEN=64, sign-extended
        @(negedge clk) issue(3'b010, 1, 0, 64'h4, 64'h0); rdata64 = 64'h8000_0000_0000_0000; ready = 1;
        #1 chk("lw64_be", 64'(be64), 64'hF0);
        @(posedge clk); #1 chk("lw64_data", read_w64, 64'hFFFF_FFFF_8000_0000);

        // Reset while BUSY
        @(negedge clk) issue(3'b010, 1, 0, 64'h300, 64'h0); ready = 0;
        @(posedge clk);
        @(negedge clk) chk("busy_stall", 64'(stall32), 64'h1);
        rst_n = 0;
        #1 chk("abort_req", 64'(req32), 64'h0);
        chk("abort_stall", 64'(stall32), 64'h0);
        chk("abort_rw", 64'(rw_w32), 64'h0);
        chk("abort_alu", 64'(alu_w32), 64'h0);
        chk("abort_rd", 64'(rd_w32), 64'h0);
        @(negedge clk) rst_n = 1; issue(3'b010, 1, 0, 64'h400, 64'h0); rdata32 = 32'hDEAD_BEEF; ready = 1;
        #1 chk("post_req", 64'(req32), 64'h1);
        chk("post_addr", 64'(addr32), 64'h400);
        @(posedge clk); #1 chk("post_data", 64'(read_w32), 64'hDEAD_BEEF);
        chk("post_rw", 64'(rw_w32), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised successor to the fixed single-cycle memory stage: the M→W stage of the RISC-V pipeline.
- Adds:
  - XLEN-generic datapath.
  - Byte/half/word (and doubleword when XLEN=64) loads and stores with byte enables.
  - Sign/zero extension of load data.
  - Misalignment exception.
  - Request/ready data-memory handshake with variable latency, stalling upstream until completion.
- Sits between the execute-stage pipeline register and writeback; drives an external data memory.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- RAW, 5, register-address width.
- RSW, 2, result_src width (00 ALU, 01 load, 10 PC+4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_m  in  1  M-stage instruction valid.
- reg_write_m  in  1  writes rd.
- mem_read_m  in  1  load.
- mem_write_m  in  1  store.
- result_src_m  in  RSW  writeback select.
- funct3_m  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- rd_m  in  RAW  destination register.
- pc_plus4_m  in  XLEN  PC+4.
- alu_result_m  in  XLEN  result / effective address.
- write_data_m  in  XLEN  store data (unshifted).
- stall_m  out  1  upstream must hold all *_m inputs.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  XLEN  address, aligned to XLEN/8.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_ready  in  1  request complete (read data valid the same cycle).
- mem_rdata  in  XLEN  read data (full word).
- reg_write_w  out  1  WB write enable.
- result_src_w  out  RSW  WB select.
- rd_w  out  RAW  WB destination.
- pc_plus4_w  out  XLEN  WB PC+4.
- alu_result_w  out  XLEN  WB ALU result.
- read_data_w  out  XLEN  extended load data.
- exc_w  out  1  misaligned or illegal-size access retired this cycle.

Behaviour:
- Reset: every W output is 0, the FSM is in IDLE, and mem_req and stall_m are 0. Asynchronous assert, synchronous release on clk.
- Access means `valid_m & (mem_read_m | mem_write_m)`.
  - Legal iff the address is naturally aligned for its size.
  - funct3 011/110 are illegal when XLEN=32; 111 is always illegal.
- mem_addr is alu_result_m with its low log2(XLEN/8) bits cleared.
- mem_be selects the size-wide lane at the offset.
- mem_wdata is write_data_m shifted left by 8·offset.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - A legal access drives mem_req=1 combinationally, along with mem_we/addr/be/wdata.
  - If mem_ready=1 in the same cycle, the W register captures on that edge (0 wait states) and stall_m=0.
  - Otherwise the request fields are latched, the FSM goes to BUSY, and stall_m=1.
- BUSY:
  - mem_req stays 1 with the latched fields, unchanged each cycle.
  - stall_m=1 until the cycle mem_ready=1. That cycle has stall_m=0, the W register captures, and the FSM returns to IDLE.
- While stalled, the W register loads a bubble each edge: reg_write_w=0, exc_w=0, other fields don't-care.
- Non-access valid instruction: 1-cycle pass-through, no mem_req, stall_m=0.
- Invalid instruction (valid_m=0): the W register loads a bubble.
- Illegal/misaligned access:
  - No mem_req.
  - 1 cycle.
  - W captures with reg_write_w=0 and exc_w=1.
  - alu_result_w holds the faulting address.
- Load extraction: take mem_rdata >> 8·offset, truncate to the size, then sign-extend (B/H/W) or zero-extend (BU/HU/WU). D passes through.
- Store completion writes no register; reg_write_w follows reg_write_m, which the decoder drives to 0.
- mem_ready while in IDLE with no request is ignored.
- Reset during BUSY aborts the transaction immediately: mem_req drops, and no W update occurs.

Test Plan:
- XLEN=32, LB addr 0x103, mem_rdata 0x80AA_BBCC, mem_ready in the same cycle → next edge read_data_w=0xFFFF_FF80, reg_write_w=1, stall_m never 1.
- LHU addr 0x102, mem_ready after 3 cycles, rdata 0x9234_5678 →
  - stall_m=1 for 3 cycles, with mem_addr=0x100 and mem_be=4'b1100 stable throughout.
  - 3 bubbles, then read_data_w=0x0000_9234.
- SB addr 0x201, write_data 0x0000_00A5 → mem_we=1, mem_be=4'b0010, mem_wdata=0x0000_A500.
- LW addr 0x102 → no mem_req, exc_w=1 for one cycle, reg_write_w=0, alu_result_w=0x102.
- XLEN=64, LD addr 0x8, rdata 0x1122_3344_5566_7788 after 1 wait → read_data_w=0x1122_3344_5566_7788; with XLEN=32 funct3 011 → exc_w=1.
- Assert rst_n=0 mid-BUSY → mem_req=0, all W outputs 0, FSM IDLE; after release, a new LW completes normally.
